mem_stream_loader: RTL and testbench

MEM_STREAM_LOADER -- requirements
Module: mem_stream_loader

---
 rtl/mem_stream_loader.sv | 115 +++++++++++
 tb/tb_mem_stream_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_loader.sv
// Byte-stream to 32-bit word memory loader with big-endian assembly.
// Optional running checksum of written words: define LOADER_CHECKSUM_EN.
module mem_stream_loader #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [9:0]        len_words,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [9:0]        words_loaded,
    output logic [31:0]       checksum
);

    localparam logic [9:0] DEPTH_L = 10'(DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t      state;
    logic [9:0]  target;
    logic [1:0]  idx;
    logic [23:0] part;
    logic [9:0]  start_target;
    logic [9:0]  wl_next;
    logic        xfer;

    // Clamp to DEPTH so the word address can never wrap.
    assign start_target = (len_words > DEPTH_L) ? DEPTH_L : len_words;
    assign wl_next      = words_loaded + 10'd1;
    assign xfer         = in_valid && in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            target       <= '0;
            idx          <= '0;
            part         <= '0;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        target       <= start_target;
                        words_loaded <= '0;
                        idx          <= '0;
                        done         <= 1'b0;
                        if (start_target == 10'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= RECV;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (xfer) begin
                        part <= {part[15:0], in_data};
                        idx  <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            state     <= WRITE;
                            in_ready  <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_addr  <= words_loaded[ADDR_W-1:0];
                            mem_wdata <= {part, in_data};
                        end
                    end
                end
                WRITE: begin
                    words_loaded <= wl_next;
                    if (wl_next == target) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state    <= RECV;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            checksum <= '0;
        end else if (start && (state == IDLE || state == DONE)) begin
            checksum <= '0;
        end else if (state == WRITE) begin
            checksum <= checksum + mem_wdata;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_stream_loader.sv
// Scoreboard bench for mem_stream_loader: driver pushes expected writes,
// a forked monitor pops and compares on every mem_we.
module tb_mem_stream_loader;

    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [9:0]        len_words = '0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic [9:0]        words_loaded;
    logic [31:0]       checksum;

    mem_stream_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .start(start),
        .len_words(len_words), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .words_loaded(words_loaded), .checksum(checksum)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] exp_sum(input logic [31:0] s);
`ifdef LOADER_CHECKSUM_EN
        return s;
`else
        return 32'd0;
`endif
    endfunction

    task automatic do_start(input int len);
        start = 1'b1;
        len_words = 10'(len);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        int cnt;
        repeat ($urandom_range(0, gapmax)) @(negedge clock);
        in_valid = 1'b1;
        in_data = b;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(negedge clock);
            cnt++;
        end
        chk("in_ready wait", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic push_bytes(input logic [31:0] w, input int gapmax);
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], gapmax);
    endtask

    task automatic wait_done(input int budget);
        int cnt = 0;
        while (!done && cnt < budget) begin
            @(negedge clock);
            cnt++;
        end
        chk("done", {31'd0, done}, 32'd1);
    endtask

    task automatic run_words(input int len, input logic [31:0] words[$],
                             input int gapmax);
        int n;
        logic [31:0] sum = 0;
        n = (len > DEPTH) ? DEPTH : len;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(32'(i));
            exp_data.push_back(words[i]);
            sum += words[i];
        end
        do_start(len);
        if (n == 0) begin
            chk("len0 done next cycle", {31'd0, done}, 32'd1);
            chk("len0 busy", {31'd0, busy}, 32'd0);
        end
        for (int i = 0; i < n; i++) push_bytes(words[i], gapmax);
        wait_done(50);
        chk("words_loaded", 32'(words_loaded), 32'(n));
        chk("busy at end", {31'd0, busy}, 32'd0);
        chk("checksum", checksum, exp_sum(sum));
        chk("pending writes", 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic run_random(input int len, input bit incr, input int gapmax);
        logic [31:0] words[$];
        int n;
        n = (len > DEPTH) ? DEPTH : len;
        for (int i = 0; i < n; i++) words.push_back(incr ? 32'(i) : $urandom);
        run_words(len, words, gapmax);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, " mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " done"}, {31'd0, done}, 32'd0);
        chk({tag, " words_loaded"}, 32'(words_loaded), 32'd0);
        chk({tag, " checksum"}, checksum, 32'd0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] q[$];

        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        fork
            forever begin
                @(negedge clock);
                if (mem_we) begin
                    chk("in_ready during write", {31'd0, in_ready}, 32'd0);
                    if (exp_addr.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected write: addr %h data %h, expected none",
                                 mem_addr, mem_wdata);
                    end else begin
                        chk("mem_addr", 32'(mem_addr), exp_addr.pop_front());
                        chk("mem_wdata", mem_wdata, exp_data.pop_front());
                    end
                end
            end
        join_none

        q = '{32'h12345678, 32'hAABBCCDD};
        run_words(2, q, 0);

        run_random(0, 1'b0, 0);

        // Stall mid-word while start is pulsed; start must be ignored.
        w = $urandom;
        exp_addr.push_back(32'd0);
        exp_data.push_back(w);
        do_start(1);
        send_byte(w[31:24], 0);
        send_byte(w[23:16], 0);
        start = 1'b1;
        len_words = 10'd7;
        repeat (3) @(negedge clock);
        chk("busy in stall", {31'd0, busy}, 32'd1);
        start = 1'b0;
        send_byte(w[15:8], 0);
        send_byte(w[7:0], 0);
        wait_done(20);
        chk("stall words_loaded", 32'(words_loaded), 32'd1);
        chk("stall pending", 32'(exp_addr.size()), 32'd0);

        for (int t = 0; t < 6; t++)
            run_random($urandom_range(1, 20), 1'b0, $urandom_range(0, 3));

        run_random(600, 1'b1, 0);

        // Reset after five bytes: first word written, partial discarded.
        w = $urandom;
        exp_addr.push_back(32'd0);
        exp_data.push_back(w);
        do_start(4);
        push_bytes(w, 1);
        send_byte(8'($urandom), 0);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clock);
        chk_all_zero("midload reset");
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        chk("idle after reset busy", {31'd0, busy}, 32'd0);
        chk("reset pending", 32'(exp_addr.size()), 32'd0);
        q = '{32'h00000001};
        run_words(1, q, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
